// File: rtl/branch_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : branch_seq_if
// Brief    : Decoder/datapath bundle for the conditional-branch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_seq_if;
    logic        start;
    logic [1:0]  c2;
    logic        con;
    logic [1:0]  cond_sel;
    logic        Gra;
    logic        Rout;
    logic        CONin;
    logic        PCout;
    logic        Yin;
    logic        Cout;
    logic        alu_add;
    logic        Zin;
    logic        Zlowout;
    logic        PCin;
    logic        busy;
    logic        done;
    logic        taken;
    logic [15:0] taken_cnt;
    logic [15:0] ntaken_cnt;

    modport master (
        output start, c2, con,
        input  cond_sel, Gra, Rout, CONin, PCout, Yin, Cout, alu_add, Zin,
               Zlowout, PCin, busy, done, taken, taken_cnt, ntaken_cnt
    );

    modport slave (
        input  start, c2, con,
        output cond_sel, Gra, Rout, CONin, PCout, Yin, Cout, alu_add, Zin,
               Zlowout, PCin, busy, done, taken, taken_cnt, ntaken_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : branch_seq
// Brief    : T3-T6 control-step sequencer for the conditional-branch instruction.
// Revision : 1.0 - initial release
// ============================================================================
module branch_seq (
    input  wire logic   clock,
    input  wire logic   reset,
    branch_seq_if.slave bus
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cond_sel;
    logic        r_taken;
    logic [15:0] r_taken_cnt;
    logic [15:0] r_ntaken_cnt;
    logic        w_accept;

    logic w_gra, w_rout, w_conin, w_pcout, w_yin;
    logic w_cout, w_alu_add, w_zin, w_zlowout, w_done;

    // A new branch is only accepted from IDLE or on the final step of the current one.
    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_T6));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cond_sel   <= 2'b00;
            r_taken      <= 1'b0;
            r_taken_cnt  <= 16'h0000;
            r_ntaken_cnt <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cond_sel <= bus.c2;
            end
            if (r_state == S_T6) begin
                r_taken <= bus.con;
                if (bus.con) begin
                    if (r_taken_cnt != c_CNT_MAX) begin
                        r_taken_cnt <= r_taken_cnt + 16'd1;
                    end
                end else begin
                    if (r_ntaken_cnt != c_CNT_MAX) begin
                        r_ntaken_cnt <= r_ntaken_cnt + 16'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_T3 : S_IDLE;
            S_T3:    w_next = S_T4;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = S_T6;
            S_T6:    w_next = w_accept ? S_T3 : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_gra     = 1'b0;
        w_rout    = 1'b0;
        w_conin   = 1'b0;
        w_pcout   = 1'b0;
        w_yin     = 1'b0;
        w_cout    = 1'b0;
        w_alu_add = 1'b0;
        w_zin     = 1'b0;
        w_zlowout = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_T3: begin
                w_gra   = 1'b1;
                w_rout  = 1'b1;
                w_conin = 1'b1;
            end
            S_T4: begin
                w_pcout = 1'b1;
                w_yin   = 1'b1;
            end
            S_T5: begin
                w_cout    = 1'b1;
                w_alu_add = 1'b1;
                w_zin     = 1'b1;
            end
            S_T6: begin
                w_zlowout = 1'b1;
                w_done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.cond_sel   = r_cond_sel;
    assign bus.Gra        = w_gra;
    assign bus.Rout       = w_rout;
    assign bus.CONin      = w_conin;
    assign bus.PCout      = w_pcout;
    assign bus.Yin        = w_yin;
    assign bus.Cout       = w_cout;
    assign bus.alu_add    = w_alu_add;
    assign bus.Zin        = w_zin;
    assign bus.Zlowout    = w_zlowout;
    // con was loaded in T3, so by T6 it reflects this branch's condition.
    assign bus.PCin       = (r_state == S_T6) && bus.con;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = w_done;
    assign bus.taken      = r_taken;
    assign bus.taken_cnt  = r_taken_cnt;
    assign bus.ntaken_cnt = r_ntaken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_branch_seq
// Brief    : Scoreboard bench for branch_seq with a condition flip-flop model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_seq;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    branch_seq_if bus ();

    branch_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         phase;   // 0 idle, 1..4 = T3..T6
        logic [1:0] c2;
        logic       tk;
    } phase_t;

    typedef struct {
        logic        tk;
        logic [15:0] tc;
        logic [15:0] nc;
    } res_t;

    phase_t ph_q[$];
    res_t   res_q[$];
    phase_t p;
    res_t   r;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] ra_val = 32'h0;

    int          m_pos = 0;
    logic [1:0]  m_c2  = 2'b00;
    logic        m_tk  = 1'b0;
    logic [15:0] m_tc  = 16'h0;
    logic [15:0] m_nc  = 16'h0;

    function automatic logic cond_true(input logic [1:0] c, input logic [31:0] v);
        case (c)
            2'b00:   return (v == 32'h0);
            2'b01:   return (v != 32'h0);
            2'b10:   return !v[31];
            default: return v[31];
        endcase
    endfunction

    // Condition flip-flop: evaluates the Ra value against the latched code when loaded.
    always @(posedge clock) begin
        if (bus.CONin) bus.con <= cond_true(bus.cond_sel, ra_val);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Order: Gra Rout CONin PCout Yin Cout alu_add Zin Zlowout PCin done busy
    function automatic logic [11:0] strobes_for(input int ph, input logic tk);
        case (ph)
            1:       return 12'b111_00_000_000_1;
            2:       return 12'b000_11_000_000_1;
            3:       return 12'b000_00_111_000_1;
            4:       return {9'b000_00_000_1, tk, 2'b11};
            default: return 12'b0;
        endcase
    endfunction

    function automatic logic [11:0] dut_strobes();
        return {bus.Gra, bus.Rout, bus.CONin, bus.PCout, bus.Yin, bus.Cout,
                bus.alu_add, bus.Zin, bus.Zlowout, bus.PCin, bus.done, bus.busy};
    endfunction

    // One clock of stimulus; the model decides acceptance from branch position.
    task automatic cycle(input bit s, input logic [1:0] c, input logic [31:0] v);
        @(posedge clock);
        #1;
        bus.start = s;
        bus.c2    = c;
        if (s && (m_pos == 0 || m_pos == 4)) begin
            ra_val = v;
            m_c2   = c;
            m_tk   = cond_true(c, v);
            if (m_tk) begin
                if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
            end else begin
                if (m_nc != 16'hFFFF) m_nc = m_nc + 16'd1;
            end
            res_q.push_back('{m_tk, m_tc, m_nc});
            m_pos = 1;
        end else begin
            m_pos = (m_pos == 0 || m_pos == 4) ? 0 : m_pos + 1;
        end
        ph_q.push_back('{m_pos, m_c2, m_tk});
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_out", {17'h0, bus.cond_sel, dut_strobes(), bus.taken,
                          bus.taken_cnt, bus.ntaken_cnt}, 64'h0);
        ph_q.delete();
        res_q.delete();
        m_pos     = 0;
        m_tc      = 16'h0;
        m_nc      = 16'h0;
        bus.start = 1'b0;
        bus.c2    = 2'b00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        ph_q.push_back('{0, 2'b00, 1'b0});
        mon_en = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && ph_q.size() > 0) begin
                p = ph_q.pop_front();
                check("strobes", {52'h0, dut_strobes()}, {52'h0, strobes_for(p.phase, p.tk)});
                if (p.phase != 0) check("cond_sel", {62'h0, bus.cond_sel}, {62'h0, p.c2});
                if (bus.done) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL res_underflow actual=done required=no_done");
                    end else begin
                        r = res_q.pop_front();
                        @(posedge clock);
                        #2;
                        check("taken", {63'h0, bus.taken}, {63'h0, r.tk});
                        check("taken_cnt", {48'h0, bus.taken_cnt}, {48'h0, r.tc});
                        check("ntaken_cnt", {48'h0, bus.ntaken_cnt}, {48'h0, r.nc});
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        bus.start = 1'b0;
        bus.c2    = 2'b00;
        do_reset();

        // Reset in the middle of T4.
        cycle(1'b1, 2'b00, 32'h0);
        cycle(1'b0, 2'b00, 32'h0);
        cycle(1'b0, 2'b00, 32'h0);
        do_reset();
        repeat (5) cycle(1'b0, 2'b00, 32'h0);

        // Taken brzr, then not-taken brnz.
        cycle(1'b1, 2'b00, 32'h0);
        repeat (5) cycle(1'b0, 2'b00, 32'h0);
        cycle(1'b1, 2'b01, 32'h0);
        repeat (5) cycle(1'b0, 2'b00, 32'h0);

        // Back-to-back: start held for 12 cycles, outcomes 1,0,1.
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 2'b00, (i == 4) ? 32'h5 : 32'h0);
        repeat (6) cycle(1'b0, 2'b00, 32'h0);

        // Start pulses in T4 and T5 are dropped.
        cycle(1'b1, 2'b10, 32'h1);
        cycle(1'b0, 2'b00, 32'h0);
        cycle(1'b1, 2'b11, 32'h0);
        cycle(1'b1, 2'b11, 32'h0);
        repeat (5) cycle(1'b0, 2'b00, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       v = 32'h0;
                1:       v = $urandom;
                default: v = $urandom | 32'h8000_0000;
            endcase
            cycle(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), v);
        end
        repeat (6) cycle(1'b0, 2'b00, 32'h0);

        // Saturation: preload the taken counter just below its ceiling.
        force dut.r_taken_cnt = 16'hFFFE;
        #1 release dut.r_taken_cnt;
        m_tc = 16'hFFFE;
        for (int i = 0; i < 12; i++) cycle(1'b1, 2'b00, 32'h0);
        repeat (6) cycle(1'b0, 2'b00, 32'h0);

        @(posedge clock);
        @(negedge clock);
        #1;
        check("ph_drain", 64'(ph_q.size()), 64'h0);
        check("res_drain", 64'(res_q.size()), 64'h0);
        check("sat_final", {48'h0, bus.taken_cnt}, 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
